// File: rtl/washing_plant_pkg.sv
// Shared constants for the washing-machine plant model: default durations,
// fault-cause bit positions and a width helper for the phase timers.
package washing_plant_pkg;

  localparam int LEVEL_MAX_DEF   = 8;
  localparam int SOAP_CYCLES_DEF = 3;
  localparam int WASH_CYCLES_DEF = 6;
  localparam int SPIN_CYCLES_DEF = 4;
  localparam int CNT_W_DEF       = 8;

  // Bit positions inside the per-cycle fault-cause vector.
  localparam int FLT_VALVES = 0;  // fill and drain valves open together
  localparam int FLT_MOTOR  = 1;  // drum driven with the door unlocked
  localparam int FLT_PHASE  = 2;  // soap and rinse phases claimed together
  localparam int FLT_N      = 3;

  typedef logic [FLT_N-1:0] fault_cause_t;

  // Bits needed to hold a count of 0..limit.
  function automatic int timer_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/washing_plant_phase_timer.sv
// Saturating phase timer: counts enabled cycles up to LIMIT; clear wins over
// count. The expired flag is registered from the post-update count.
module phase_timer
  import washing_plant_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int W = timer_width(LIMIT);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count;
  logic [W-1:0] count_next;

  // Next count: clear has priority, otherwise increment until saturated.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (count_en && (count != LIM)) begin
      count_next = count + 1'b1;
    end
  end

  // Count register and registered expiry flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_next;
      expired <= (count_next == LIM);
    end
  end

endmodule

// File: rtl/washing_plant.sv
// Behavioural washing-machine plant: turns controller actuator commands into
// tank level, dispense/agitation/spin timeouts, a sticky fault flag and a
// completed-cycle counter. All outputs respond one cycle after the command.
module washing_plant
  import washing_plant_pkg::*;
#(
  parameter int LEVEL_MAX   = LEVEL_MAX_DEF,
  parameter int SOAP_CYCLES = SOAP_CYCLES_DEF,
  parameter int WASH_CYCLES = WASH_CYCLES_DEF,
  parameter int SPIN_CYCLES = SPIN_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             door_lock,
  input  logic                             motor_on,
  input  logic                             fill_value_on,
  input  logic                             drain_value_on,
  input  logic                             soap_wash,
  input  logic                             water_wash,
  input  logic                             done,
  output logic                             filled,
  output logic                             drained,
  output logic                             detergent_added,
  output logic                             cycle_timeout,
  output logic                             spin_timeout,
  output logic                             fault,
  output logic [$clog2(LEVEL_MAX+1)-1:0]   level,
  output logic [CNT_W-1:0]                 done_count
);

  localparam int LW = $clog2(LEVEL_MAX + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(LEVEL_MAX);

  logic [LW-1:0] level_next;
  fault_cause_t  cause;
  logic          done_prev;
  logic          motor_clear;

  // Tank level: one step per cycle on a single open valve, saturating at
  // empty and full; both valves or neither leave the level alone.
  always_comb begin
    level_next = level;
    case ({fill_value_on, drain_value_on})
      2'b10:   if (level != LVL_FULL) level_next = level + 1'b1;
      2'b01:   if (level != '0)       level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Illegal actuator combinations seen this cycle.
  always_comb begin
    cause             = '0;
    cause[FLT_VALVES] = fill_value_on & drain_value_on;
    cause[FLT_MOTOR]  = motor_on & ~door_lock;
    cause[FLT_PHASE]  = soap_wash & water_wash;
  end

  // Level, full/empty flags, sticky fault and completed-cycle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level      <= '0;
      filled     <= 1'b0;
      drained    <= 1'b1;
      fault      <= 1'b0;
      done_prev  <= 1'b0;
      done_count <= '0;
    end else begin
      level     <= level_next;
      filled    <= (level_next == LVL_FULL);
      drained   <= (level_next == '0);
      fault     <= fault | (|cause);
      done_prev <= done;
      if (done && !done_prev) begin
        done_count <= done_count + 1'b1;
      end
    end
  end

  // Agitation and spin only make sense with the drum running behind a
  // locked door; losing either restarts them.
  assign motor_clear = ~motor_on | ~door_lock;

  phase_timer #(.LIMIT(SOAP_CYCLES)) u_soap (
    .clk      (clk),
    .reset    (reset),
    .count_en (soap_wash),
    .clear    (~soap_wash),
    .expired  (detergent_added)
  );

  // Agitation needs a full tank and a closed drain; losing only those holds.
  phase_timer #(.LIMIT(WASH_CYCLES)) u_wash (
    .clk      (clk),
    .reset    (reset),
    .count_en (motor_on & door_lock & filled & ~drain_value_on),
    .clear    (motor_clear),
    .expired  (cycle_timeout)
  );

  phase_timer #(.LIMIT(SPIN_CYCLES)) u_spin (
    .clk      (clk),
    .reset    (reset),
    .count_en (motor_on & door_lock & drain_value_on),
    .clear    (motor_clear),
    .expired  (spin_timeout)
  );

endmodule

// File: tb/tb_washing_plant.sv
// Closed-form bench for washing_plant: a reference model predicts every
// output per cycle, predictions queue up when inputs are driven and are
// popped and compared one cycle later. A second instance with a 2-bit
// counter shares the inputs to exercise counter wrap.
module tb_washing_plant;

  localparam int EW = 20;

  logic clk = 1'b0;
  logic reset, door_lock, motor_on, fill_value_on, drain_value_on;
  logic soap_wash, water_wash, done;
  logic filled, drained, detergent_added, cycle_timeout, spin_timeout, fault;
  logic [3:0] level;
  logic [7:0] done_count;
  logic filled_w, drained_w, det_w, ct_w, st_w, fault_w;
  logic [3:0] level_w;
  logic [1:0] done_count_w;

  int n_vec  = 0;
  int n_fail = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state.
  int m_level, m_soap, m_wash, m_spin, m_dcnt;
  bit m_fault, m_dprev;

  washing_plant dut (
    .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
    .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
    .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
    .filled(filled), .drained(drained), .detergent_added(detergent_added),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
    .fault(fault), .level(level), .done_count(done_count)
  );

  washing_plant #(.CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
    .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
    .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
    .filled(filled_w), .drained(drained_w), .detergent_added(det_w),
    .cycle_timeout(ct_w), .spin_timeout(st_w),
    .fault(fault_w), .level(level_w), .done_count(done_count_w)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    bit filled_now;
    if (!reset) begin
      m_level = 0; m_soap = 0; m_wash = 0; m_spin = 0;
      m_dcnt = 0; m_fault = 0; m_dprev = 0;
      return;
    end
    filled_now = (m_level == 8);
    if ((fill_value_on && drain_value_on) || (motor_on && !door_lock) ||
        (soap_wash && water_wash))
      m_fault = 1;
    if (fill_value_on && !drain_value_on && m_level < 8) m_level++;
    else if (drain_value_on && !fill_value_on && m_level > 0) m_level--;
    m_soap = soap_wash ? ((m_soap < 3) ? m_soap + 1 : 3) : 0;
    if (!motor_on || !door_lock) begin
      m_wash = 0;
      m_spin = 0;
    end else begin
      if (filled_now && !drain_value_on && m_wash < 6) m_wash++;
      if (drain_value_on && m_spin < 4) m_spin++;
    end
    if (done && !m_dprev) m_dcnt = (m_dcnt + 1) % 256;
    m_dprev = done;
  endtask

  // Drive one cycle: predict, push, clock, pop and compare.
  task automatic step();
    logic [EW-1:0] e, g;
    model_step();
    e = {(m_level == 8) ? 1'b1 : 1'b0, (m_level == 0) ? 1'b1 : 1'b0,
         (m_soap == 3) ? 1'b1 : 1'b0, (m_wash == 6) ? 1'b1 : 1'b0,
         (m_spin == 4) ? 1'b1 : 1'b0, m_fault, 4'(m_level), 8'(m_dcnt),
         2'(m_dcnt)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = {filled, drained, detergent_added, cycle_timeout, spin_timeout,
         fault, level, done_count, done_count_w};
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("filled",   32'(g[19]),    32'(e[19]));
      check("drained",  32'(g[18]),    32'(e[18]));
      check("det_add",  32'(g[17]),    32'(e[17]));
      check("cyc_to",   32'(g[16]),    32'(e[16]));
      check("spin_to",  32'(g[15]),    32'(e[15]));
      check("fault",    32'(g[14]),    32'(e[14]));
      check("level",    32'(g[13:10]), 32'(e[13:10]));
      check("done_cnt", 32'(g[9:2]),   32'(e[9:2]));
      check("done_w",   32'(g[1:0]),   32'(e[1:0]));
    end
  endtask

  task automatic idle_inputs();
    door_lock = 0; motor_on = 0; fill_value_on = 0; drain_value_on = 0;
    soap_wash = 0; water_wash = 0; done = 0;
  endtask

  task automatic repeat_step(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int widths[5];
    widths = '{1, 4, 1, 2, 1};
    idle_inputs();
    reset = 0;
    #1;
    repeat_step(2);
    reset = 1;
    step();
    check("rst_level", 32'(level), 32'd0);
    check("rst_drained", 32'(drained), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);

    // Fill past full.
    fill_value_on = 1;
    step();
    check("fill1_drained", 32'(drained), 32'd0);
    repeat_step(9);
    fill_value_on = 0;
    check("full_level", 32'(level), 32'd8);
    check("full_flag", 32'(filled), 32'd1);

    // Agitate at full level, then drop the motor.
    door_lock = 1; motor_on = 1;
    repeat_step(5);
    check("wash_5", 32'(cycle_timeout), 32'd0);
    step();
    check("wash_6", 32'(cycle_timeout), 32'd1);
    motor_on = 0;
    step();
    check("wash_drop", 32'(cycle_timeout), 32'd0);

    // Spin-drain from full.
    motor_on = 1; drain_value_on = 1;
    repeat_step(4);
    check("spin_4", 32'(spin_timeout), 32'd1);
    repeat_step(4);
    check("drain_level", 32'(level), 32'd0);
    check("drain_flag", 32'(drained), 32'd1);
    repeat_step(2);
    check("spin_hold", 32'(spin_timeout), 32'd1);
    idle_inputs();
    step();

    // Soap dispense.
    soap_wash = 1;
    repeat_step(4);
    check("soap_done", 32'(detergent_added), 32'd1);
    soap_wash = 0;
    step();
    check("soap_clear", 32'(detergent_added), 32'd0);

    // Done pulses, one of them 4 cycles wide.
    for (int p = 0; p < 5; p++) begin
      done = 1;
      repeat_step(widths[p]);
      done = 0;
      repeat_step(2);
      if (p == 2) check("done_3", 32'(done_count), 32'd3);
    end
    check("done_5", 32'(done_count), 32'd5);
    check("done_wrap", 32'(done_count_w), 32'd1);

    // Both valves open: level holds, fault latches until reset.
    fill_value_on = 1; drain_value_on = 1;
    step();
    idle_inputs();
    check("valve_fault", 32'(fault), 32'd1);
    check("valve_level", 32'(level), 32'd0);
    repeat_step(3);
    check("fault_sticky", 32'(fault), 32'd1);
    reset = 0;
    step();
    reset = 1;
    step();
    check("fault_reset", 32'(fault), 32'd0);
    motor_on = 1; door_lock = 0;
    step();
    check("motor_fault", 32'(fault), 32'd1);

    // Random closed-loop traffic against the model.
    for (int i = 0; i < 200; i++) begin
      reset          = ($urandom_range(0, 31) != 0);
      door_lock      = ($urandom_range(0, 3) != 0);
      motor_on       = ($urandom_range(0, 2) != 0);
      fill_value_on  = ($urandom_range(0, 2) == 0);
      drain_value_on = ($urandom_range(0, 2) == 0);
      soap_wash      = ($urandom_range(0, 1) == 0);
      water_wash     = ($urandom_range(0, 5) == 0);
      done           = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
